// File: rtl/seg_scan_ctrl.sv
// seg_scan_ctrl: time-multiplexed scan of a shared BCD-to-7-segment decoder; optional leading-zero blanking under SEG_SCAN_LZB_EN.
// Latency: outputs are registered and change on the clock edge that enters a phase; loaded values appear at the next frame boundary.
// Backpressure: none; load is a fire-and-forget strobe (last load per frame wins) and lamp_req is sampled only on the last SHOW cycle.
module seg_scan_ctrl #(
  parameter int NUM_DIGITS   = 4,
  parameter int DIGIT_CYCLES = 50000,
  parameter int GUARD_CYCLES = 500,
  parameter int LT_CYCLES    = 5000000
) (
  input  logic                      clk,
  input  logic                      rst,
  input  logic [4*NUM_DIGITS-1:0]   value,
  input  logic                      load,
  input  logic [NUM_DIGITS-1:0]     blank_mask,
  input  logic                      lamp_req,
  output logic [3:0]                dec_D,
  output logic                      dec_LE,
  output logic                      dec_BL,
  output logic                      dec_LT,
  output logic [NUM_DIGITS-1:0]     dig_sel,
  output logic                      frame_done
);

  localparam int SLOT_W = $clog2(DIGIT_CYCLES);
  localparam int LT_W   = (LT_CYCLES > 1) ? $clog2(LT_CYCLES) : 1;
  localparam int DIG_W  = $clog2(NUM_DIGITS);

  localparam logic [SLOT_W-1:0] SLOT_LAST = SLOT_W'(DIGIT_CYCLES - 1);
  localparam logic [SLOT_W-1:0] GUARD_END = SLOT_W'(GUARD_CYCLES);
  localparam logic [LT_W-1:0]   LT_LAST   = LT_W'(LT_CYCLES - 1);
  localparam logic [DIG_W-1:0]  DIG_LAST  = DIG_W'(NUM_DIGITS - 1);

  // S_INIT only exists for the single cycle of reset; it always moves to S_LAMP.
  typedef enum logic [1:0] {
    S_INIT  = 2'd0,
    S_LAMP  = 2'd1,
    S_GUARD = 2'd2,
    S_SHOW  = 2'd3
  } state_t;

  // A zero-length guard means every slot opens directly in SHOW.
  localparam state_t SLOT_FIRST = (GUARD_CYCLES == 0) ? S_SHOW : S_GUARD;

  state_t                  state, state_nxt;
  logic [SLOT_W-1:0]       slot_cnt, slot_nxt, slot_inc;
  logic [LT_W-1:0]         lt_cnt, lt_nxt;
  logic [DIG_W-1:0]        dig, dig_nxt;
  logic [4*NUM_DIGITS-1:0] disp, disp_nxt;
  logic [4*NUM_DIGITS-1:0] pending;
  logic                    pend_valid;
  logic                    boundary;
  logic                    frame_end;
  logic [NUM_DIGITS-1:0]   lz_blank;
  logic [3:0]              show_nib;
  logic                    show_blank;

  assign slot_inc = slot_cnt + 1'b1;

  // Next-state: one slot counter spans guard+show; the lamp counter is separate because it is far longer.
  always_comb begin
    state_nxt = state;
    slot_nxt  = slot_cnt;
    lt_nxt    = lt_cnt;
    dig_nxt   = dig;
    boundary  = 1'b0;
    frame_end = 1'b0;
    case (state)
      S_INIT: begin
        state_nxt = S_LAMP;
        lt_nxt    = '0;
      end
      S_LAMP: begin
        if (lt_cnt == LT_LAST) begin
          state_nxt = SLOT_FIRST;
          slot_nxt  = '0;
          dig_nxt   = '0;
          boundary  = 1'b1;
        end else begin
          lt_nxt = lt_cnt + 1'b1;
        end
      end
      S_GUARD, S_SHOW: begin
        if (slot_cnt == SLOT_LAST) begin
          // Last cycle of a slot is always SHOW, so this is where lamp_req is looked at.
          slot_nxt = '0;
          if (dig == DIG_LAST) begin
            frame_end = 1'b1;
          end
          if (lamp_req) begin
            state_nxt = S_LAMP;
            lt_nxt    = '0;
          end else begin
            state_nxt = SLOT_FIRST;
            if (dig == DIG_LAST) begin
              dig_nxt  = '0;
              boundary = 1'b1;
            end else begin
              dig_nxt = dig + 1'b1;
            end
          end
        end else begin
          slot_nxt = slot_inc;
          if (slot_inc == GUARD_END) begin
            state_nxt = S_SHOW;
          end
        end
      end
      default: begin
        state_nxt = S_INIT;
      end
    endcase
  end

  // Commit pending data only on a frame boundary so a frame never mixes old and new nibbles.
  always_comb begin
    disp_nxt = disp;
    if (boundary && pend_valid) begin
      disp_nxt = pending;
    end
  end

`ifdef SEG_SCAN_LZB_EN
  // Digit i>0 is leading-zero blanked when it and every more significant nibble are zero.
  always_comb begin
    logic all_zero;
    lz_blank = '0;
    all_zero = 1'b1;
    for (int i = NUM_DIGITS - 1; i > 0; i--) begin
      all_zero    = all_zero & (disp_nxt[4*i +: 4] == 4'd0);
      lz_blank[i] = all_zero;
    end
  end
`else
  // Zeros are shown; only blank_mask can blank a digit.
  assign lz_blank = '0;
`endif

  // Select the nibble and blanking for the digit about to be shown.
  always_comb begin
    show_nib   = 4'd0;
    show_blank = 1'b0;
    for (int i = 0; i < NUM_DIGITS; i++) begin
      if (dig_nxt == DIG_W'(i)) begin
        show_nib   = disp_nxt[4*i +: 4];
        show_blank = blank_mask[i] | lz_blank[i];
      end
    end
  end

  // FSM state, data registers and outputs; outputs are decoded from the next state so they line up with it.
  always_ff @(posedge clk) begin
    if (rst) begin
      state      <= S_INIT;
      slot_cnt   <= '0;
      lt_cnt     <= '0;
      dig        <= '0;
      disp       <= '0;
      pending    <= '0;
      pend_valid <= 1'b0;
      dec_D      <= 4'd0;
      dec_LE     <= 1'b0;
      dec_BL     <= 1'b0;
      dec_LT     <= 1'b1;
      dig_sel    <= '0;
      frame_done <= 1'b0;
    end else begin
      state    <= state_nxt;
      slot_cnt <= slot_nxt;
      lt_cnt   <= lt_nxt;
      dig      <= dig_nxt;
      disp     <= disp_nxt;

      // A load coinciding with a boundary lands in pending and waits a full frame.
      if (load) begin
        pending    <= value;
        pend_valid <= 1'b1;
      end else if (boundary) begin
        pend_valid <= 1'b0;
      end

      frame_done <= frame_end;
      dec_LE     <= 1'b0;

      case (state_nxt)
        S_LAMP: begin
          dec_D   <= 4'd0;
          dec_BL  <= 1'b1;
          dec_LT  <= 1'b0;
          dig_sel <= '1;
        end
        S_GUARD: begin
          dec_D   <= 4'd0;
          dec_BL  <= 1'b0;
          dec_LT  <= 1'b1;
          dig_sel <= '0;
        end
        S_SHOW: begin
          dec_D   <= show_nib;
          dec_BL  <= ~show_blank;
          dec_LT  <= 1'b1;
          dig_sel <= show_blank ? '0 : (NUM_DIGITS'(1) << dig_nxt);
        end
        default: begin
          dec_D   <= 4'd0;
          dec_BL  <= 1'b0;
          dec_LT  <= 1'b1;
          dig_sel <= '0;
        end
      endcase
    end
  end

endmodule

// File: tb/tb_seg_scan_ctrl.sv
// tb_seg_scan_ctrl: directed scan/load/blank/lamp/reset sequence for seg_scan_ctrl with a per-cycle expectation queue.
// Latency: expectations for each output cycle are queued ahead and compared on the falling edge after the DUT updates.
// Backpressure: none; the bench drives strobes on falling edges so they are sampled by the following rising edge.
module tb_seg_scan_ctrl;

  localparam int ND = 4;
  localparam int DC = 8;
  localparam int GC = 2;
  localparam int LC = 16;

  typedef struct packed {
    logic [3:0] sel;
    logic [3:0] d;
    logic       d_care;
    logic       bl;
    logic       lt;
    logic       le;
    logic       fd;
  } exp_t;

  logic          clk = 1'b0;
  logic          rst;
  logic [15:0]   value;
  logic          load;
  logic [3:0]    blank_mask;
  logic          lamp_req;
  logic [3:0]    dec_D;
  logic          dec_LE;
  logic          dec_BL;
  logic          dec_LT;
  logic [3:0]    dig_sel;
  logic          frame_done;

  exp_t sb_q[$];
  int   checks = 0;
  int   errors = 0;
  int   cyc    = 0;

  seg_scan_ctrl #(
    .NUM_DIGITS  (ND),
    .DIGIT_CYCLES(DC),
    .GUARD_CYCLES(GC),
    .LT_CYCLES   (LC)
  ) dut (
    .clk       (clk),
    .rst       (rst),
    .value     (value),
    .load      (load),
    .blank_mask(blank_mask),
    .lamp_req  (lamp_req),
    .dec_D     (dec_D),
    .dec_LE    (dec_LE),
    .dec_BL    (dec_BL),
    .dec_LT    (dec_LT),
    .dig_sel   (dig_sel),
    .frame_done(frame_done)
  );

  always #5 clk = ~clk;

  function automatic exp_t e_reset();
    exp_t e;
    e = '{sel: 4'b0000, d: 4'h0, d_care: 1'b1, bl: 1'b0, lt: 1'b1, le: 1'b0, fd: 1'b0};
    return e;
  endfunction

  function automatic exp_t e_lamp();
    exp_t e;
    e = '{sel: 4'b1111, d: 4'h0, d_care: 1'b1, bl: 1'b1, lt: 1'b0, le: 1'b0, fd: 1'b0};
    return e;
  endfunction

  function automatic exp_t e_guard(input logic fd);
    exp_t e;
    e = '{sel: 4'b0000, d: 4'h0, d_care: 1'b0, bl: 1'b0, lt: 1'b1, le: 1'b0, fd: fd};
    return e;
  endfunction

  function automatic exp_t e_show(input int dig, input logic [3:0] d, input logic blank);
    exp_t e;
    e.sel    = blank ? 4'b0000 : (4'b0001 << dig);
    e.d      = d;
    e.d_care = ~blank;
    e.bl     = ~blank;
    e.lt     = 1'b1;
    e.le     = 1'b0;
    e.fd     = 1'b0;
    return e;
  endfunction

  task automatic push(input exp_t e, input int n);
    repeat (n) sb_q.push_back(e);
  endtask

  task automatic push_slot(input int dig, input logic [3:0] d, input logic blank, input logic fd);
    push(e_guard(fd), 1);
    push(e_guard(1'b0), GC - 1);
    push(e_show(dig, d, blank), DC - GC);
  endtask

  task automatic push_frame(input logic [15:0] v, input logic [3:0] mask, input logic fd_first);
    for (int i = 0; i < ND; i++) begin
      logic bl;
      bl = mask[i];
`ifdef SEG_SCAN_LZB_EN
      if (i > 0 && (v >> (4 * i)) == 16'h0000) bl = 1'b1;
`endif
      push_slot(i, v[4*i +: 4], bl, fd_first && (i == 0));
    end
  endtask

  // Sample n output cycles on falling edges and compare each against the queue head.
  task automatic drain(input int n, input string tag);
    exp_t e;
    exp_t obs;
    for (int k = 0; k < n; k++) begin
      @(negedge clk);
      cyc++;
      checks++;
      if (sb_q.size() == 0) begin
        errors++;
        $error("FAIL %s cyc%0d expectation queue empty, observed sel=%b D=%h", tag, cyc, dig_sel, dec_D);
      end else begin
        e          = sb_q.pop_front();
        obs.sel    = dig_sel;
        obs.d      = e.d_care ? dec_D : e.d;
        obs.d_care = e.d_care;
        obs.bl     = dec_BL;
        obs.lt     = dec_LT;
        obs.le     = dec_LE;
        obs.fd     = frame_done;
        assert (obs === e) else begin
          errors++;
          $error("FAIL %s cyc%0d observed sel=%b D=%h BL=%b LT=%b LE=%b fd=%b expected sel=%b D=%h BL=%b LT=%b LE=%b fd=%b",
                 tag, cyc, dig_sel, dec_D, dec_BL, dec_LT, dec_LE, frame_done,
                 e.sel, e.d, e.bl, e.lt, e.le, e.fd);
        end
      end
    end
  endtask

  initial begin
    rst        = 1'b1;
    value      = 16'h0000;
    load       = 1'b0;
    blank_mask = 4'b0000;
    lamp_req   = 1'b0;
    repeat (2) @(posedge clk);

    // Reset values while rst is held.
    push(e_reset(), 1);
    drain(1, "reset");

    // Lamp test after reset; load 1234 during it, committed at LAMP exit.
    rst = 1'b0;
    push(e_lamp(), LC);
    drain(2, "lamp_init");
    value = 16'h1234; load = 1'b1;
    drain(1, "lamp_init");
    load = 1'b0;
    drain(LC - 3, "lamp_init");

    // Frame A shows 1234; two loads mid-frame, the last one wins next frame.
    push_frame(16'h1234, 4'b0000, 1'b0);
    drain(10, "frame_1234");
    value = 16'h5678; load = 1'b1;
    drain(1, "frame_1234");
    load = 1'b0;
    drain(5, "frame_1234");
    value = 16'h9ABC; load = 1'b1;
    drain(1, "frame_1234");
    load = 1'b0;
    drain(15, "frame_1234");

    // Frame B shows 9ABC (nibbles above 9 pass through), frame_done on its first cycle.
    push_frame(16'h9ABC, 4'b0000, 1'b1);
    drain(32, "frame_9abc");

    // Frame C with digit 2 masked.
    blank_mask = 4'b0100;
    push_frame(16'h9ABC, 4'b0100, 1'b1);
    drain(32, "blank_mask");
    blank_mask = 4'b0000;

    // Load on the wrap edge: frame D still shows 9ABC, frame E shows 0807.
    value = 16'h0807; load = 1'b1;
    push_frame(16'h9ABC, 4'b0000, 1'b1);
    drain(1, "load_at_wrap");
    load = 1'b0;
    drain(31, "load_at_wrap");

    // Frame E: a lamp_req away from the last SHOW cycle is ignored; one on digit 1's last cycle enters LAMP.
    push_frame(16'h0807, 4'b0000, 1'b1);
    while (sb_q.size() > 2 * DC) void'(sb_q.pop_back());
    drain(4, "lamp_ignored");
    lamp_req = 1'b1;
    drain(1, "lamp_ignored");
    lamp_req = 1'b0;
    drain(11, "lamp_ignored");
    lamp_req = 1'b1;
    push(e_lamp(), LC);
    drain(1, "lamp_req");
    lamp_req = 1'b0;
    drain(LC - 1, "lamp_req");

    // After LAMP the scan restarts at digit 0 without a frame_done.
    push_frame(16'h0807, 4'b0000, 1'b0);
    drain(32, "after_lamp");

    // Reset mid-SHOW of digit 0 discards a pending FFFF and clears the display.
    push(e_guard(1'b1), 1);
    push(e_guard(1'b0), GC - 1);
    push(e_show(0, 4'h7, 1'b0), 3);
    drain(2, "pre_reset");
    value = 16'hFFFF; load = 1'b1;
    drain(1, "pre_reset");
    load = 1'b0;
    drain(2, "pre_reset");
    rst = 1'b1;
    push(e_reset(), 1);
    drain(1, "mid_reset");
    rst = 1'b0;
    push(e_lamp(), LC);
    drain(LC, "lamp_after_rst");
    push_frame(16'h0000, 4'b0000, 1'b0);
    drain(32, "cleared");

    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule
